apb_rr_arbiter: RTL

- Round-robin scheduler that shares one APB master port among NUM_REQ local requesters in the b_pclk domain.
- Each requester presents a command with a level valid. The arbiter grants one requester, runs the APB SETUP/ACCESS sequence, and returns rdata/error with a one-cycle done pulse.
- An optional ACCESS-phase timeout protects against a hung slave.
- It sits between the low-frequency APB command sources and the b_p* APB bus.

---
 rtl/apb_rr_arbiter.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/apb_rr_arbiter.sv
// Round-robin arbiter sharing one APB master port among NUM_REQ requesters.
// Runs SETUP/ACCESS, returns rdata/err with a one-cycle done pulse.
module apb_rr_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ADDR_WD     = 32,
  parameter int DATA_WD     = 32,
  parameter int STRB_WD     = 4,
  parameter int PROT_WD     = 3,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                       b_pclk,
  input  logic                       b_prst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ-1:0]         req_write,
  input  logic [NUM_REQ*ADDR_WD-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WD-1:0] req_wdata,
  input  logic [NUM_REQ*PROT_WD-1:0] req_prot,
  input  logic [NUM_REQ*STRB_WD-1:0] req_strb,
  output logic [NUM_REQ-1:0]         req_done,
  output logic [DATA_WD-1:0]         rsp_rdata,
  output logic                       rsp_err,
  output logic                       rsp_timeout,
  output logic                       b_psel,
  output logic                       b_penable,
  output logic                       b_pwrite,
  output logic [ADDR_WD-1:0]         b_paddr,
  output logic [DATA_WD-1:0]         b_pwdata,
  output logic [PROT_WD-1:0]         b_pprot,
  output logic [STRB_WD-1:0]         b_pstrb,
  input  logic [DATA_WD-1:0]         b_prdata,
  input  logic                       b_pready,
  input  logic                       b_pslverr
);

  localparam int PW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WCW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam bit TO_EN = (TIMEOUT_CYC != 0);
  localparam logic [WCW-1:0] TO_LAST =
    TO_EN ? WCW'(TIMEOUT_CYC - 1) : '0;
  localparam logic [PW-1:0] LAST_ID = PW'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    COMPLETE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [PW-1:0]      rr_ptr;
  logic [PW-1:0]      grant_id;
  logic [PW-1:0]      ptr_nx;
  logic [WCW-1:0]     wait_cnt;
  logic [NUM_REQ-1:0] done_oh;
  logic               to_hit;

  logic               any_req;
  logic [PW-1:0]      sel_id;
  logic               sel_write;
  logic [ADDR_WD-1:0] sel_addr;
  logic [DATA_WD-1:0] sel_wdata;
  logic [PROT_WD-1:0] sel_prot;
  logic [STRB_WD-1:0] sel_strb;
  int                 k;

  // Circular scan from rr_ptr; first valid requester wins.
  always_comb begin
    any_req   = 1'b0;
    sel_id    = '0;
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_prot  = '0;
    sel_strb  = '0;
    k         = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = int'(rr_ptr) + i;
      if (k >= NUM_REQ) k = k - NUM_REQ;
      if (!any_req && req_valid[k]) begin
        any_req   = 1'b1;
        sel_id    = PW'(k);
        sel_write = req_write[k];
        sel_addr  = req_addr[k*ADDR_WD +: ADDR_WD];
        sel_wdata = req_wdata[k*DATA_WD +: DATA_WD];
        sel_prot  = req_prot[k*PROT_WD +: PROT_WD];
        sel_strb  = req_strb[k*STRB_WD +: STRB_WD];
      end
    end
  end

  always_comb begin
    to_hit  = TO_EN && (wait_cnt == TO_LAST) && !b_pready;
    ptr_nx  = (grant_id == LAST_ID) ? '0 : grant_id + PW'(1);
    done_oh = NUM_REQ'(1) << grant_id;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:     if (any_req) state_nx = SETUP;
      SETUP:    state_nx = ACCESS;
      ACCESS:   if (b_pready || to_hit) state_nx = COMPLETE;
      COMPLETE: state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge b_pclk) begin
    if (b_prst) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge b_pclk) begin
    if (b_prst) begin
      rr_ptr      <= '0;
      grant_id    <= '0;
      wait_cnt    <= '0;
      b_psel      <= 1'b0;
      b_penable   <= 1'b0;
      b_pwrite    <= 1'b0;
      b_paddr     <= '0;
      b_pwdata    <= '0;
      b_pprot     <= '0;
      b_pstrb     <= '0;
      req_done    <= '0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      req_done    <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      unique case (state)
        IDLE: begin
          if (any_req) begin
            grant_id <= sel_id;
            b_psel   <= 1'b1;
            b_pwrite <= sel_write;
            b_paddr  <= sel_addr;
            b_pwdata <= sel_wdata;
            b_pprot  <= sel_prot;
            b_pstrb  <= sel_strb;
          end
        end
        SETUP: begin
          b_penable <= 1'b1;
          wait_cnt  <= '0;
        end
        ACCESS: begin
          // pready wins over a timeout landing in the same cycle
          if (b_pready) begin
            b_psel    <= 1'b0;
            b_penable <= 1'b0;
            req_done  <= done_oh;
            rsp_rdata <= b_pwrite ? '0 : b_prdata;
            rsp_err   <= b_pslverr;
            rr_ptr    <= ptr_nx;
          end else if (to_hit) begin
            b_psel      <= 1'b0;
            b_penable   <= 1'b0;
            req_done    <= done_oh;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
            rr_ptr      <= ptr_nx;
          end else begin
            wait_cnt <= wait_cnt + WCW'(1);
          end
        end
        COMPLETE: ;
        default: ;
      endcase
    end
  end

endmodule
